// File: rtl/ifetch_queue.sv
// In-order instruction prefetch queue between a non-stalling icache and decode.
// A redirect flushes the queue and drops the responses still owed by the icache.

module ifetch_queue #(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] reset_adr_i,
    output logic            icache_req_o,
    output logic [XLEN-1:0] icache_adr_o,
    input  logic            icache_rsp_v_i,
    input  logic [31:0]     icache_instr_i,
    input  logic            branch_v_q_i,
    input  logic            exception_q_i,
    input  logic [XLEN-1:0] pc_data_q_i,
    output logic            instr_v_o,
    output logic [31:0]     instr_q_o,
    output logic [XLEN-1:0] pc_q_o,
    input  logic            dec_ready_i
);

    logic                  boot_q, boot_d;
    logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]       rsp_pc_q, rsp_pc_d;
    logic [31:0]           instr_mem_q [DEPTH];
    logic [31:0]           instr_mem_d [DEPTH];
    logic [XLEN-1:0]       pc_mem_q [DEPTH];
    logic [XLEN-1:0]       pc_mem_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;

    logic                  redirect_s, issue_s, push_s, discard_s, head_v_s, pop_s;
    logic [CNT_W+1:0]      pending_s;

    // Handshake decode from registered counts only
    always_comb begin
        redirect_s = branch_v_q_i | exception_q_i;
        pending_s  = (CNT_W+2)'(occ_q) + (CNT_W+2)'(outst_q) + (CNT_W+2)'(drop_q);
        // Stale responses still hold a slot, so the buffer can never be overcommitted
        issue_s    = ~boot_q & ~redirect_s & (pending_s < (CNT_W+2)'(DEPTH));
        push_s     = ~boot_q & ~redirect_s & icache_rsp_v_i & (drop_q == {CNT_W{1'b0}});
        discard_s  = ~boot_q & ~redirect_s & icache_rsp_v_i & (drop_q != {CNT_W{1'b0}});
        head_v_s   = (occ_q != {CNT_W{1'b0}}) & ~redirect_s;
        pop_s      = head_v_s & dec_ready_i;
    end

    // Next-state computation for the fetch pointers, queue and counters
    always_comb begin
        boot_d      = boot_q;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        if (boot_q) begin
            boot_d     = 1'b0;
            fetch_pc_d = reset_adr_i;
            rsp_pc_d   = reset_adr_i;
        end else if (redirect_s) begin
            fetch_pc_d = pc_data_q_i;
            rsp_pc_d   = pc_data_q_i;
            rd_ptr_d   = wr_ptr_q;
            occ_d      = {CNT_W{1'b0}};
            outst_d    = {CNT_W{1'b0}};
            drop_d     = drop_q + outst_q - CNT_W'(icache_rsp_v_i);
        end else begin
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                instr_mem_d[wr_ptr_q] = icache_instr_i;
                pc_mem_d[wr_ptr_q]    = rsp_pc_q;
                rsp_pc_d              = rsp_pc_q + XLEN'(4);
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            outst_d  = outst_q + CNT_W'(issue_s) - CNT_W'(push_s);
            occ_d    = occ_q + CNT_W'(push_s) - CNT_W'(pop_s);
            drop_d   = drop_q - CNT_W'(discard_s);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_q     <= 1'b1;
            fetch_pc_q <= {XLEN{1'b0}};
            rsp_pc_q   <= {XLEN{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            occ_q      <= {CNT_W{1'b0}};
            outst_q    <= {CNT_W{1'b0}};
            drop_q     <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0;
                pc_mem_q[i]    <= {XLEN{1'b0}};
            end
        end else begin
            boot_q      <= boot_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    assign icache_req_o = issue_s;
    assign icache_adr_o = fetch_pc_q;
    assign instr_v_o    = head_v_s;
    assign instr_q_o    = instr_mem_q[rd_ptr_q];
    assign pc_q_o       = pc_mem_q[rd_ptr_q];

    ifetch_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .rsp_v (icache_rsp_v_i),
        .occ   (occ_q),
        .outst (outst_q),
        .drop  (drop_q)
    );

endmodule

// Protocol and occupancy properties of the prefetch queue.
module ifetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             rsp_v,
    input logic [CNT_W-1:0] occ,
    input logic [CNT_W-1:0] outst,
    input logic [CNT_W-1:0] drop
);

    logic [CNT_W+1:0] total_s;

    assign total_s = (CNT_W+2)'(occ) + (CNT_W+2)'(outst) + (CNT_W+2)'(drop);

    a_rsp_owed: assert property (@(posedge clk) disable iff (reset)
        rsp_v |-> ((outst != {CNT_W{1'b0}}) || (drop != {CNT_W{1'b0}})));

    a_slots_bounded: assert property (@(posedge clk) disable iff (reset)
        total_s <= (CNT_W+2)'(DEPTH));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a fixed-latency in-order icache model.

module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] reset_adr_i = 32'h0;
    logic        icache_req_o;
    logic [31:0] icache_adr_o;
    logic        icache_rsp_v_i;
    logic [31:0] icache_instr_i;
    logic        branch_v_q_i = 1'b0;
    logic        exception_q_i = 1'b0;
    logic [31:0] pc_data_q_i = 32'h0;
    logic        instr_v_o;
    logic [31:0] instr_q_o;
    logic [31:0] pc_q_o;
    logic        dec_ready_i = 1'b1;

    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    int          cyc = 0;
    logic        ring_v [16];
    logic [31:0] ring_a [16];
    logic [3:0]  wi, ri;
    logic [31:0] dq_pc[$];
    logic [31:0] dq_ins[$];

    ifetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .reset_adr_i    (reset_adr_i),
        .icache_req_o   (icache_req_o),
        .icache_adr_o   (icache_adr_o),
        .icache_rsp_v_i (icache_rsp_v_i),
        .icache_instr_i (icache_instr_i),
        .branch_v_q_i   (branch_v_q_i),
        .exception_q_i  (exception_q_i),
        .pc_data_q_i    (pc_data_q_i),
        .instr_v_o      (instr_v_o),
        .instr_q_o      (instr_q_o),
        .pc_q_o         (pc_q_o),
        .dec_ready_i    (dec_ready_i)
    );

    always #5 clk = ~clk;

    // icache: answers each request exactly lat cycles later with ~address
    initial begin
        icache_rsp_v_i = 1'b0;
        icache_instr_i = 32'h0;
        for (int i = 0; i < 16; i++) begin
            ring_v[i] = 1'b0;
            ring_a[i] = 32'h0;
        end
        forever begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
            wi = cyc[3:0];
            ri = wi - lat[3:0];
            if (reset) begin
                for (int i = 0; i < 16; i++) ring_v[i] = 1'b0;
                icache_rsp_v_i = 1'b0;
                icache_instr_i = 32'h0;
            end else begin
                icache_rsp_v_i = ring_v[ri];
                icache_instr_i = ring_v[ri] ? ~ring_a[ri] : 32'h0;
                ring_v[wi] = icache_req_o;
                ring_a[wi] = icache_adr_o;
            end
        end
    end

    // Record every instruction decode accepts
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && instr_v_o && dec_ready_i) begin
                dq_pc.push_back(pc_q_o);
                dq_ins.push_back(instr_q_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of the boot cycle
    task automatic do_reset(input logic [31:0] base);
        reset = 1'b1;
        branch_v_q_i = 1'b0;
        exception_q_i = 1'b0;
        reset_adr_i = base;
        tick(); tick(); tick();
        dq_pc.delete();
        dq_ins.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat = 1;
        dec_ready_i = 1'b1;
        reset_adr_i = 32'h8000_0000;
        tick(); tick(); tick();
        #3;
        checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", icache_req_o); end
        checks++; if (icache_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr: got %h want 0", icache_adr_o); end
        checks++; if (instr_v_o !== 1'b0) begin errors++; $display("FAIL rst_instr_v: got %0b want 0", instr_v_o); end
        checks++; if (instr_q_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr_q_o); end
        checks++; if (pc_q_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_q_o); end
        tick();
        reset = 1'b0;
        #3;
        checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL boot_req: got %0b want 0", icache_req_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        tick(); #3;
        checks++; if (icache_req_o !== 1'b1 || icache_adr_o !== 32'h8000_0000) begin
            errors++; $display("FAIL stream_req0: got req=%0b adr=%h want 1 80000000", icache_req_o, icache_adr_o); end
        tick(); #3;
        checks++; if (icache_req_o !== 1'b1 || icache_adr_o !== 32'h8000_0004 || instr_v_o !== 1'b0) begin
            errors++; $display("FAIL stream_req1: got req=%0b adr=%h v=%0b want 1 80000004 0", icache_req_o, icache_adr_o, instr_v_o); end
        for (int k = 0; k < 8; k++) begin
            tick(); #3;
            exp_pc = 32'h8000_0000 + 32'(4 * k);
            checks++; if (instr_v_o !== 1'b1 || pc_q_o !== exp_pc || instr_q_o !== ~exp_pc) begin
                errors++; $display("FAIL stream_head%0d: got v=%0b pc=%h ins=%h want 1 %h %h", k, instr_v_o, pc_q_o, instr_q_o, exp_pc, ~exp_pc); end
        end
    endtask

    task automatic test_full();
        logic        exp_req;
        logic [31:0] exp_adr;
        dec_ready_i = 1'b0;
        lat = 1;
        do_reset(32'h0000_1000);
        for (int k = 1; k <= 10; k++) begin
            tick(); #3;
            exp_req = (k <= 4);
            exp_adr = 32'h0000_1000 + 32'(4 * (k - 1));
            checks++; if (icache_req_o !== exp_req || (exp_req && icache_adr_o !== exp_adr)) begin
                errors++; $display("FAIL full_req%0d: got req=%0b adr=%h want %0b %h", k, icache_req_o, icache_adr_o, exp_req, exp_adr); end
        end
        checks++; if (instr_v_o !== 1'b1 || pc_q_o !== 32'h0000_1000) begin
            errors++; $display("FAIL full_head: got v=%0b pc=%h want 1 00001000", instr_v_o, pc_q_o); end
        tick();
        dec_ready_i = 1'b1;
        #3;
        checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL full_no_credit: got %0b want 0", icache_req_o); end
        tick(); #3;
        checks++; if (icache_req_o !== 1'b1 || icache_adr_o !== 32'h0000_1010) begin
            errors++; $display("FAIL full_refill: got req=%0b adr=%h want 1 00001010", icache_req_o, icache_adr_o); end
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (dq_pc.size() <= i || dq_pc[i] !== 32'h0000_1000 + 32'(4 * i) || dq_ins[i] !== ~(32'h0000_1000 + 32'(4 * i))) begin
                errors++; $display("FAIL full_pop%0d: got n=%0d pc=%h want %h", i, dq_pc.size(), (dq_pc.size() > i) ? dq_pc[i] : 32'hx, 32'h0000_1000 + 32'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        int found;
        int wait_k;
        dec_ready_i = 1'b1;
        lat = 3;
        do_reset(32'h0000_2000);
        repeat (4) tick();
        tick();
        branch_v_q_i = 1'b1;
        pc_data_q_i = 32'h0000_0100;
        #3;
        checks++; if (instr_v_o !== 1'b0 || icache_req_o !== 1'b0) begin
            errors++; $display("FAIL br_cycle: got v=%0b req=%0b want 0 0", instr_v_o, icache_req_o); end
        tick();
        branch_v_q_i = 1'b0;
        #3;
        checks++; if (icache_req_o !== 1'b1 || icache_adr_o !== 32'h0000_0100) begin
            errors++; $display("FAIL br_target_req: got req=%0b adr=%h want 1 00000100", icache_req_o, icache_adr_o); end
        found = 0;
        wait_k = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(); #3;
            if (instr_v_o) begin found = 1; wait_k = k; break; end
        end
        checks++; if (found != 1 || wait_k != 4 || pc_q_o !== 32'h0000_0100 || instr_q_o !== ~32'h0000_0100) begin
            errors++; $display("FAIL br_first: got found=%0d wait=%0d pc=%h want 1 4 00000100", found, wait_k, pc_q_o); end
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (dq_pc.size() <= i || dq_pc[i] !== 32'h0000_0100 + 32'(4 * i)) begin
                errors++; $display("FAIL br_seq%0d: got n=%0d pc=%h want %h", i, dq_pc.size(), (dq_pc.size() > i) ? dq_pc[i] : 32'hx, 32'h0000_0100 + 32'(4 * i)); end
        end
    endtask

    task automatic test_exception();
        int found;
        int wait_k;
        lat = 2;
        do_reset(32'h0000_3000);
        repeat (2) tick();
        tick();
        exception_q_i = 1'b1;
        pc_data_q_i = 32'h0000_0400;
        #3;
        checks++; if (icache_req_o !== 1'b0 || instr_v_o !== 1'b0) begin
            errors++; $display("FAIL exc_cycle: got req=%0b v=%0b want 0 0", icache_req_o, instr_v_o); end
        tick();
        exception_q_i = 1'b0;
        #3;
        checks++; if (icache_req_o !== 1'b1 || icache_adr_o !== 32'h0000_0400) begin
            errors++; $display("FAIL exc_target_req: got req=%0b adr=%h want 1 00000400", icache_req_o, icache_adr_o); end
        found = 0;
        wait_k = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(); #3;
            if (instr_v_o) begin found = 1; wait_k = k; break; end
        end
        checks++; if (found != 1 || wait_k != 3 || pc_q_o !== 32'h0000_0400) begin
            errors++; $display("FAIL exc_first: got found=%0d wait=%0d pc=%h want 1 3 00000400", found, wait_k, pc_q_o); end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checks++; if (dq_pc.size() <= i || dq_pc[i] !== 32'h0000_0400 + 32'(4 * i)) begin
                errors++; $display("FAIL exc_seq%0d: got n=%0d pc=%h want %h", i, dq_pc.size(), (dq_pc.size() > i) ? dq_pc[i] : 32'hx, 32'h0000_0400 + 32'(4 * i)); end
        end
    endtask

    task automatic test_back_to_back();
        int found;
        int wait_k;
        lat = 2;
        do_reset(32'h0000_5000);
        repeat (2) tick();
        tick();
        branch_v_q_i = 1'b1;
        pc_data_q_i = 32'h0000_0600;
        #3;
        checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL b2b_first: got req=%0b want 0", icache_req_o); end
        tick();
        branch_v_q_i = 1'b0;
        exception_q_i = 1'b1;
        pc_data_q_i = 32'h0000_0700;
        #3;
        checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL b2b_second: got req=%0b want 0", icache_req_o); end
        tick();
        exception_q_i = 1'b0;
        #3;
        checks++; if (icache_req_o !== 1'b1 || icache_adr_o !== 32'h0000_0700) begin
            errors++; $display("FAIL b2b_target_req: got req=%0b adr=%h want 1 00000700", icache_req_o, icache_adr_o); end
        found = 0;
        wait_k = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(); #3;
            if (instr_v_o) begin found = 1; wait_k = k; break; end
        end
        checks++; if (found != 1 || wait_k != 3 || pc_q_o !== 32'h0000_0700) begin
            errors++; $display("FAIL b2b_first_instr: got found=%0d wait=%0d pc=%h want 1 3 00000700", found, wait_k, pc_q_o); end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checks++; if (dq_pc.size() <= i || dq_pc[i] !== 32'h0000_0700 + 32'(4 * i)) begin
                errors++; $display("FAIL b2b_seq%0d: got n=%0d pc=%h want %h", i, dq_pc.size(), (dq_pc.size() > i) ? dq_pc[i] : 32'hx, 32'h0000_0700 + 32'(4 * i)); end
        end
    endtask

    task automatic test_reset_mid();
        lat = 3;
        dec_ready_i = 1'b0;
        do_reset(32'h0000_4000);
        repeat (5) tick();
        tick(); #3;
        checks++; if (instr_v_o !== 1'b1 || pc_q_o !== 32'h0000_4000 || instr_q_o !== ~32'h0000_4000) begin
            errors++; $display("FAIL mid_pre: got v=%0b pc=%h want 1 00004000", instr_v_o, pc_q_o); end
        reset = 1'b1;
        #1;
        checks++; if (icache_req_o !== 1'b0) begin errors++; $display("FAIL mid_req: got %0b want 0", icache_req_o); end
        checks++; if (icache_adr_o !== 32'h0) begin errors++; $display("FAIL mid_adr: got %h want 0", icache_adr_o); end
        checks++; if (instr_v_o !== 1'b0) begin errors++; $display("FAIL mid_instr_v: got %0b want 0", instr_v_o); end
        checks++; if (instr_q_o !== 32'h0) begin errors++; $display("FAIL mid_instr: got %h want 0", instr_q_o); end
        checks++; if (pc_q_o !== 32'h0) begin errors++; $display("FAIL mid_pc: got %h want 0", pc_q_o); end
        reset_adr_i = 32'h0000_9000;
        lat = 1;
        dec_ready_i = 1'b1;
        tick(); tick();
        dq_pc.delete();
        dq_ins.delete();
        reset = 1'b0;
        tick(); #3;
        checks++; if (icache_req_o !== 1'b1 || icache_adr_o !== 32'h0000_9000) begin
            errors++; $display("FAIL mid_restart_req: got req=%0b adr=%h want 1 00009000", icache_req_o, icache_adr_o); end
        tick(); #3;
        checks++; if (instr_v_o !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got v=%0b want 0", instr_v_o); end
        tick(); #3;
        checks++; if (instr_v_o !== 1'b1 || pc_q_o !== 32'h0000_9000) begin
            errors++; $display("FAIL mid_first: got v=%0b pc=%h want 1 00009000", instr_v_o, pc_q_o); end
        repeat (3) tick();
        checks++; if (dq_pc.size() < 1 || dq_pc[0] !== 32'h0000_9000) begin
            errors++; $display("FAIL mid_seq: got n=%0d pc=%h want 00009000", dq_pc.size(), (dq_pc.size() > 0) ? dq_pc[0] : 32'hx); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_branch();
        test_exception();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
